serial_add_ctrl: RTL and testbench

- Bit-serial addition controller that time-shares one external 1-bit full_adder_top to add two WIDTH-bit operands.
- Each operand bit is presented LSB-first, one bit per clock. The controller stores the carry between bits and assembles the sum word.
- It sits between a requester (start/done handshake) and the combinational full adder.

---
 rtl/serial_add_ctrl_if.sv | 40 ++++
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result and full-adder signals for serial_add_ctrl.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_in1;
    logic             fa_in2;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_carry;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    // Controller side
    modport slave (
        input  start, a, b, cin, fa_sum, fa_carry,
        output busy, done, sum, cout, fa_in1, fa_in2, fa_cin
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );

    // Requester / adder side
    modport master (
        output start, a, b, cin, fa_sum, fa_carry,
        input  busy, done, sum, cout, fa_in1, fa_in2, fa_cin
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one external 1-bit full adder LSB-first,
// keeps the running carry, and assembles the WIDTH-bit sum word.
// Optional macro SERIAL_ADD_OVF_EN adds a two's-complement overflow output.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    serial_add_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             busy, done, fa_in1, fa_in2, fa_cin;

    // State register and datapath registers; reset aborts any operation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and outputs; the result word only changes at the last RUN edge
    // so the previous result stays visible for the whole next operation.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;
        fa_in1  = 1'b0;
        fa_in2  = 1'b0;
        fa_cin  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    s_sh_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                fa_in1 = a_sh_q[0];
                fa_in2 = b_sh_q[0];
                fa_cin = c_q;
                s_sh_d = {bus.fa_sum, s_sh_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = bus.fa_carry;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = {bus.fa_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = bus.fa_carry;
                    // carry into MSB xor carry out of MSB
                    ovf_d   = c_q ^ bus.fa_carry;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
    assign bus.fa_in1 = fa_in1;
    assign bus.fa_in2 = fa_in2;
    assign bus.fa_cin = fa_cin;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an arithmetic model predicts every
// output each cycle, plus hand-computed literal results for directed vectors.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    // External 1-bit full adder
    assign bus.fa_sum   = bus.fa_in1 ^ bus.fa_in2 ^ bus.fa_cin;
    assign bus.fa_carry = (bus.fa_in1 & bus.fa_in2) | (bus.fa_cin & (bus.fa_in1 ^ bus.fa_in2));

    int vectors = 0;
    int errors  = 0;
    int dones   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: cycles since acceptance ----------------
    // phase -1 = idle, 0..W-1 = serial bit being added, W = result cycle
    int             phase = -1;
    logic [W-1:0]   ma, mb;
    logic           mcin;
    logic [W-1:0]   esum = '0;
    logic           ecout = 1'b0;
    logic           eovf = 1'b0;

    always @(posedge clk) begin
        logic [W:0] full;
        int s;
        if (rst) begin
            phase = -1; esum = '0; ecout = 1'b0; eovf = 1'b0;
        end else if (phase < 0) begin
            if (bus.start) begin
                ma = bus.a; mb = bus.b; mcin = bus.cin; phase = 0;
            end
        end else if (phase < W - 1) begin
            phase++;
        end else if (phase == W - 1) begin
            full  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            esum  = full[W-1:0];
            ecout = full[W];
            s     = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
            eovf  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
            phase = W;
        end else begin
            phase = -1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic          run, ein1, ein2, ecin;
        logic [W-1:0]  mask;
        logic [W:0]    lo;
        if (bus.done === 1'b1) dones++;
        if (chk_en) begin
            run  = (phase >= 0) && (phase < W);
            ein1 = 1'b0; ein2 = 1'b0; ecin = 1'b0;
            if (run) begin
                mask = (W'(1) << phase) - W'(1);
                lo   = {1'b0, ma & mask} + {1'b0, mb & mask} + {{W{1'b0}}, mcin};
                ein1 = ma[phase];
                ein2 = mb[phase];
                ecin = lo[phase];
            end
            chk("busy",   32'(bus.busy),   32'(phase >= 0));
            chk("done",   32'(bus.done),   32'(phase == W));
            chk("sum",    32'(bus.sum),    32'(esum));
            chk("cout",   32'(bus.cout),   32'(ecout));
            chk("fa_in1", 32'(bus.fa_in1), 32'(ein1));
            chk("fa_in2", 32'(bus.fa_in2), 32'(ein2));
            chk("fa_cin", 32'(bus.fa_cin), 32'(ecin));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf",    32'(bus.ovf),    32'(eovf));
`endif
        end
    end

    // ---------------- stimulus helpers (all end at posedge+2) ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (bus.done !== 1'b1 && n < 3 * W);
        chk(name, 32'(bus.done), 32'd1);
    endtask

    task automatic step;
        @(posedge clk); #2;
    endtask

    task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] exp);
        int n;
        start_op(a, b, c);
        wait_done({name, "_done"}, n);
        chk({name, "_res"}, 32'({bus.cout, bus.sum}), 32'(exp));
        chk({name, "_mdl"}, 32'({ecout, esum}), 32'(exp));
        step();
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res",  32'({bus.cout, bus.sum}), 32'd0);
        chk("rst_fa",   32'({bus.fa_in1, bus.fa_in2, bus.fa_cin}), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; chk_en = 1'b1;

        // basic op with latency check
        start_op(8'h05, 8'h03, 1'b0);
        wait_done("t1_done", n);
        chk("t1_lat", 32'(n), 32'(W + 1));
        chk("t1_res", 32'({bus.cout, bus.sum}), 32'h008);
        step();

        op_lit("t2", 8'hFF, 8'h01, 1'b0, 9'h100);
        op_lit("t3", 8'hA5, 8'h5A, 1'b1, 9'h100);

        // starts while busy are ignored; old result held until final edge
        d0 = dones;
        start_op(8'h3C, 8'h11, 1'b1);           // accepted at edge k
        step();                                  // edge k+1
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
        step();                                  // edge k+2
        step();                                  // edge k+3 sees start
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_hold", 32'({bus.cout, bus.sum}), 32'h100);
        @(posedge clk); #2;                      // edge k+4
        repeat (3) step();                       // edge k+7
        bus.start = 1'b1;
        step();                                  // edge k+8 sees start
        bus.start = 1'b0;
        wait_done("t4_done", n);
        chk("t4_res", 32'({bus.cout, bus.sum}), 32'h04E);
        step();
        repeat (W + 4) step();
        chk("t4_ndone", 32'(dones - d0), 32'd1);

        // reset mid-run
        d0 = dones;
        start_op(8'h12, 8'h34, 1'b0);            // edge k
        repeat (3) step();                       // edge k+3
        rst = 1'b1;
        @(posedge clk); #2;                      // edge k+4 resets
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_res",  32'({bus.cout, bus.sum}), 32'd0);
        chk("t5_fa",   32'({bus.fa_in1, bus.fa_in2, bus.fa_cin}), 32'd0);
        @(posedge clk); #2;
        repeat (2 * W) step();
        chk("t5_nodone", 32'(dones - d0), 32'd0);
        op_lit("t6", 8'h12, 8'h34, 1'b1, 9'h047);

        // overflow vectors (sum/cout checked in both builds)
        op_lit("t7", 8'h7F, 8'h01, 1'b0, 9'h080);
`ifdef SERIAL_ADD_OVF_EN
        chk("t7_ovf", 32'(bus.ovf), 32'd1);
`endif
        op_lit("t8", 8'h80, 8'hFF, 1'b0, 9'h17F);
`ifdef SERIAL_ADD_OVF_EN
        chk("t8_ovf", 32'(bus.ovf), 32'd1);
`endif
        op_lit("t9", 8'h10, 8'h20, 1'b0, 9'h030);
`ifdef SERIAL_ADD_OVF_EN
        chk("t9_ovf", 32'(bus.ovf), 32'd0);
`endif

        // back-to-back: start held high, operands change every cycle
        d0 = dones;
        bus.start = 1'b1;
        for (int i = 0; i < 200 * (W + 2); i++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (W + 4) step();
        chk("b2b_ndone", 32'(dones - d0), 32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
